// File: rtl/tsc_activity_monitor_pkg.sv
// Shared constants for the activity monitor: FSM state encodings and
// default bus/window sizes.
package tsc_activity_monitor_pkg;

  localparam int DEF_WIDTH    = 128;
  localparam int DEF_WIN_LOG2 = 10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PRIME = 2'd1;
  localparam state_t ST_ACCUM = 2'd2;
  localparam state_t ST_CLOSE = 2'd3;

endpackage

// File: rtl/tsc_activity_monitor_popcount_tree.sv
// Combinational population count built as a balanced pairwise adder tree.
module popcount_tree #(
  parameter int WIDTH = 128,
  parameter int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [OUT_W-1:0] count_o
);

  localparam int LV = $clog2(WIDTH);
  localparam int P  = 1 << LV;

  // lvl[0] holds the zero-padded leaves; each level halves the node count.
  logic [OUT_W-1:0] lvl [LV+1][P];

  always_comb begin
    for (int l = 0; l <= LV; l++) begin
      for (int i = 0; i < P; i++) begin
        lvl[l][i] = '0;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      lvl[0][i] = OUT_W'(data_i[i]);
    end
    for (int l = 1; l <= LV; l++) begin
      for (int i = 0; i < (P >> l); i++) begin
        lvl[l][i] = lvl[l-1][2*i] + lvl[l-1][2*i+1];
      end
    end
  end

  assign count_o = lvl[LV][0];

endmodule

// File: rtl/tsc_activity_monitor.sv
// Switching-activity monitor: sums bit toggles of mon_in over fixed windows
// and reports each window total with a threshold flag and sticky alarms.
module tsc_activity_monitor
  import tsc_activity_monitor_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int WIN_LOG2 = DEF_WIN_LOG2,
  parameter int CNT_W    = $clog2(WIDTH) + WIN_LOG2 + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] mon_in,
  input  logic [CNT_W-1:0] thresh,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_hot,
  output logic             alarm,
  output logic             overrun,
  output logic [1:0]       dbg_state
);

  // Report handshake: a report transfers on any rising edge with
  // rpt_valid && rpt_ready; while rpt_valid is high and rpt_ready low the
  // report fields are held and newer window totals are dropped (overrun).

  localparam int PW = $clog2(WIDTH + 1);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic [WIDTH-1:0]    diff_q, diff_d;
  logic                diff_vld_q, diff_vld_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic                rpt_valid_q, rpt_valid_d;
  logic [CNT_W-1:0]    rpt_count_q, rpt_count_d;
  logic                rpt_hot_q, rpt_hot_d;
  logic                alarm_q, alarm_d;
  logic                overrun_q, overrun_d;
  logic [PW-1:0]       pop_cnt;
  logic                is_hot;

  popcount_tree #(.WIDTH(WIDTH), .OUT_W(PW)) u_popcount (
    .data_i  (diff_q),
    .count_o (pop_cnt)
  );

  assign is_hot = (acc_q >= thresh);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    diff_d      = diff_q;
    diff_vld_d  = 1'b0;
    acc_d       = acc_q;
    win_cnt_d   = win_cnt_q;
    rpt_valid_d = rpt_valid_q && !rpt_ready;
    rpt_count_d = rpt_count_q;
    rpt_hot_d   = rpt_hot_q;
    alarm_d     = alarm_q;
    overrun_d   = overrun_q;

    // Second pipeline stage: fold last cycle's Hamming distance into the sum.
    if (diff_vld_q) begin
      acc_d = acc_q + CNT_W'(pop_cnt);
    end

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else begin
          prev_d    = mon_in;
          acc_d     = '0;
          win_cnt_d = '0;
          state_d   = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else begin
          diff_d     = mon_in ^ prev_q;
          diff_vld_d = 1'b1;
          prev_d     = mon_in;
          win_cnt_d  = win_cnt_q + 1'b1;
          if (&win_cnt_q) state_d = ST_CLOSE;
        end
      end
      ST_CLOSE: begin
        // First CLOSE cycle drains the final distance; the second reports.
        if (!diff_vld_q) begin
          if (!rpt_valid_q || rpt_ready) begin
            rpt_valid_d = 1'b1;
            rpt_count_d = acc_q;
            rpt_hot_d   = is_hot;
            alarm_d     = alarm_q | is_hot;
          end else begin
            overrun_d = 1'b1;
          end
          acc_d     = '0;
          win_cnt_d = '0;
          state_d   = en ? ST_ACCUM : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      prev_q      <= '0;
      diff_q      <= '0;
      diff_vld_q  <= 1'b0;
      acc_q       <= '0;
      win_cnt_q   <= '0;
      rpt_valid_q <= 1'b0;
      rpt_count_q <= '0;
      rpt_hot_q   <= 1'b0;
      alarm_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      diff_q      <= diff_d;
      diff_vld_q  <= diff_vld_d;
      acc_q       <= acc_d;
      win_cnt_q   <= win_cnt_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_count_q <= rpt_count_d;
      rpt_hot_q   <= rpt_hot_d;
      alarm_q     <= alarm_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rpt_valid = rpt_valid_q;
  assign rpt_count = rpt_count_q;
  assign rpt_hot   = rpt_hot_q;
  assign alarm     = alarm_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tsc_activity_monitor.sv
// Directed bench for tsc_activity_monitor with 16-sample windows on a 128-bit bus.
module tb_tsc_activity_monitor;

  localparam int WIDTH    = 128;
  localparam int WIN_LOG2 = 4;
  localparam int CNT_W    = 12;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] mon_in;
  logic [CNT_W-1:0] thresh;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_count;
  logic             rpt_hot;
  logic             alarm;
  logic             overrun;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  int mode   = 0;  // 0: hold mon_in, 1: rotate right by 1, 2: flip bit 0
  int lat;
  logic [WIDTH-1:0] alt_pat;

  tsc_activity_monitor #(
    .WIDTH(WIDTH), .WIN_LOG2(WIN_LOG2), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mon_in    (mon_in),
    .thresh    (thresh),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_count (rpt_count),
    .rpt_hot   (rpt_hot),
    .alarm     (alarm),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Advance one edge, then present the next mon_in sample.
  task automatic tick();
    @(posedge clk);
    #1;
    case (mode)
      1: mon_in = {mon_in[0], mon_in[WIDTH-1:1]};
      2: mon_in[0] = ~mon_in[0];
      default: ;
    endcase
  endtask

  task automatic wait_rpt(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rpt_valid && n < 60);
    chk("rpt_arrives", {31'd0, rpt_valid}, 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    alt_pat   = {64{2'b10}};
    rst       = 1'b0;
    en        = 1'b0;
    mon_in    = '0;
    thresh    = '0;
    rpt_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", {31'd0, rpt_valid}, 0);
    chk("rst_count", {20'd0, rpt_count}, 0);
    chk("rst_hot", {31'd0, rpt_hot}, 0);
    chk("rst_alarm", {31'd0, alarm}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    chk("rst_state", {30'd0, dbg_state}, 0);
    rst = 1'b1;

    // Quiet bus: every window reports zero, never hot.
    mode = 0; mon_in = '0; thresh = 12'd1; en = 1'b1;
    for (int w = 0; w < 2; w++) begin
      wait_rpt(lat);
      chk("zero_count", {20'd0, rpt_count}, 0);
      chk("zero_hot", {31'd0, rpt_hot}, 0);
      chk("zero_alarm", {31'd0, alarm}, 0);
    end

    // Every bit toggles each sample: 16 x 128 = 2048.
    en = 1'b0; do_reset();
    mode = 1; mon_in = alt_pat; thresh = 12'd2048; en = 1'b1;
    wait_rpt(lat);
    chk("rot_latency", lat, 20);
    chk("rot_count", {20'd0, rpt_count}, 2048);
    chk("rot_hot", {31'd0, rpt_hot}, 1);
    chk("rot_alarm", {31'd0, alarm}, 1);
    wait_rpt(lat);
    chk("rot_latency2", lat, 18);
    chk("rot_count2", {20'd0, rpt_count}, 2048);

    // Single toggling bit: count 16, threshold edge at 17 vs 16.
    en = 1'b0; do_reset();
    mode = 2; mon_in = '0; thresh = 12'd17; en = 1'b1;
    wait_rpt(lat);
    chk("bit0_count", {20'd0, rpt_count}, 16);
    chk("bit0_hot_17", {31'd0, rpt_hot}, 0);
    chk("bit0_alarm_17", {31'd0, alarm}, 0);
    thresh = 12'd16;
    wait_rpt(lat);
    chk("bit0_count2", {20'd0, rpt_count}, 16);
    chk("bit0_hot_16", {31'd0, rpt_hot}, 1);
    chk("bit0_alarm_16", {31'd0, alarm}, 1);

    // Backpressure across two closes: first report held, later ones dropped.
    en = 1'b0; do_reset();
    mode = 2; mon_in = '0; thresh = 12'd100; rpt_ready = 1'b0; en = 1'b1;
    wait_rpt(lat);
    chk("bp_first_count", {20'd0, rpt_count}, 16);
    chk("bp_overrun0", {31'd0, overrun}, 0);
    mode = 0; mon_in = '0;
    repeat (20) tick();
    chk("bp_valid_held", {31'd0, rpt_valid}, 1);
    chk("bp_count_held", {20'd0, rpt_count}, 16);
    chk("bp_overrun1", {31'd0, overrun}, 1);
    repeat (20) tick();
    chk("bp_count_held2", {20'd0, rpt_count}, 16);
    rpt_ready = 1'b1;
    tick();
    chk("bp_valid_drop", {31'd0, rpt_valid}, 0);
    chk("bp_overrun_sticky", {31'd0, overrun}, 1);
    wait_rpt(lat);
    chk("bp_next_count", {20'd0, rpt_count}, 0);
    chk("bp_alarm", {31'd0, alarm}, 0);

    // Reset mid-window with a report and alarm outstanding.
    en = 1'b0; do_reset();
    mode = 1; mon_in = alt_pat; thresh = 12'd2048; rpt_ready = 1'b0; en = 1'b1;
    wait_rpt(lat);
    chk("mr_pre_alarm", {31'd0, alarm}, 1);
    repeat (5) tick();
    do_reset();
    chk("mr_valid", {31'd0, rpt_valid}, 0);
    chk("mr_count", {20'd0, rpt_count}, 0);
    chk("mr_hot", {31'd0, rpt_hot}, 0);
    chk("mr_alarm", {31'd0, alarm}, 0);
    chk("mr_overrun", {31'd0, overrun}, 0);
    chk("mr_state", {30'd0, dbg_state}, 0);
    rpt_ready = 1'b1;
    wait_rpt(lat);
    chk("mr_latency", lat, 20);
    chk("mr_count2", {20'd0, rpt_count}, 2048);

    // en drop after 7 samples: partial window discarded, fresh window after.
    en = 1'b0; do_reset();
    mode = 1; mon_in = alt_pat; thresh = 12'd17; en = 1'b1;
    repeat (9) tick();
    chk("ed_state_accum", {30'd0, dbg_state}, 2);
    en = 1'b0;
    tick();
    chk("ed_state_idle", {30'd0, dbg_state}, 0);
    repeat (25) tick();
    chk("ed_no_report", {31'd0, rpt_valid}, 0);
    mode = 2; mon_in = '0; en = 1'b1;
    wait_rpt(lat);
    chk("ed_latency", lat, 20);
    chk("ed_count", {20'd0, rpt_count}, 16);
    chk("ed_hot", {31'd0, rpt_hot}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
